// File: rtl/reset_sequencer.sv
// Ordered release of NUM_STAGES downstream resets, with done timeouts, retries,
// re-sequencing when a done drops, and heartbeat/status outputs for debug LEDs.
module reset_sequencer #(
    parameter int                    NUM_STAGES  = 4,
    parameter int                    HOLD_CYCLES = 1024,
    parameter int                    STAGE_DELAY = 256,
    parameter int                    TIMEOUT     = 65535,
    parameter int                    MAX_RETRIES = 2,
    parameter logic [NUM_STAGES-1:0] DONE_MASK   = '0,
    parameter int                    HB_BIT      = 27,
    parameter int                    CNT_W       = 17
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  ext_rst_i,
    input  logic [NUM_STAGES-1:0] done_i,
    output logic [NUM_STAGES-1:0] rst_o,
    output logic                  all_done_o,
    output logic                  timeout_o,
    output logic                  fault_o,
    output logic [2:0]            fail_stage_o,
    output logic                  heartbeat_o,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RELEASE = 3'd1,
        S_WAIT    = 3'd2,
        S_SETTLE  = 3'd3,
        S_RUN     = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]         LAST_STAGE   = 3'(NUM_STAGES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic                  r_ext_meta, r_ext_sync;
    logic [NUM_STAGES-1:0] r_done_meta, r_done_sync;
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_k;
    logic [RETRY_W-1:0]    r_retry;
    logic [NUM_STAGES-1:0] r_rst;
    logic                  r_timeout;
    logic [2:0]            r_fail;
    logic [HB_BIT:0]       r_hb;

    logic [NUM_STAGES-1:0] w_done_eff;
    logic                  w_done_cur;
    logic                  w_lost;
    logic [2:0]            w_lost_idx;
    logic                  w_reseq;
    logic [CNT_W-1:0]      w_cnt_inc;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [2:0]            w_k_nxt;
    logic [RETRY_W-1:0]    w_retry_nxt;
    logic [NUM_STAGES-1:0] w_rst_nxt;
    logic                  w_timeout_nxt;
    logic [2:0]            w_fail_nxt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value; blocking here would collapse the 2-flop synchronizer.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_ext_meta  <= 1'b0;
            r_ext_sync  <= 1'b0;
            r_done_meta <= '0;
            r_done_sync <= '0;
        end else begin
            r_ext_meta  <= ext_rst_i;
            r_ext_sync  <= r_ext_meta;
            r_done_meta <= done_i;
            r_done_sync <= r_done_meta;
        end
    end

    assign w_done_eff = r_done_sync | DONE_MASK;
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // Descending scan so the lowest lost stage wins; only stages below k count
    // outside RUN, since stage k itself is still legitimately coming up.
    always_comb begin
        w_lost     = 1'b0;
        w_lost_idx = '0;
        w_done_cur = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!w_done_eff[i] && ((r_state == S_RUN) || (i < int'(r_k)))) begin
                w_lost     = 1'b1;
                w_lost_idx = 3'(i);
            end
            if (i == int'(r_k)) begin
                w_done_cur = w_done_eff[i];
            end
        end
    end

    assign w_reseq = w_lost && (r_state inside {S_WAIT, S_SETTLE, S_RUN});

    // NOTE: every signal gets a default before the branches so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_k_nxt       = r_k;
        w_retry_nxt   = r_retry;
        w_rst_nxt     = r_rst;
        w_timeout_nxt = r_timeout;
        w_fail_nxt    = r_fail;
        if (r_ext_sync) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_k_nxt     = '0;
            w_retry_nxt = '0;
            w_rst_nxt   = '1;
        end else if (w_reseq) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_k_nxt     = w_lost_idx;
            w_retry_nxt = '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (i >= int'(w_lost_idx)) w_rst_nxt[i] = 1'b1;
            end
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RELEASE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_RELEASE: begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (i == int'(r_k)) w_rst_nxt[i] = 1'b0;
                    end
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_cur) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_SETTLE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_timeout_nxt = 1'b1;
                        w_fail_nxt    = r_k;
                        w_cnt_nxt     = '0;
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (i == int'(r_k)) w_rst_nxt[i] = 1'b1;
                        end
                        if (r_retry < RETRY_MAX) begin
                            w_retry_nxt = r_retry + 1'b1;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_state_nxt = S_FAULT;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_retry_nxt = '0;
                        w_cnt_nxt   = '0;
                        if (r_k == LAST_STAGE) begin
                            w_state_nxt = S_RUN;
                        end else begin
                            w_k_nxt     = r_k + 1'b1;
                            w_state_nxt = S_RELEASE;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_RUN:   ;
                S_FAULT: ;
                default: w_state_nxt = S_HOLD;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_k       <= '0;
            r_retry   <= '0;
            r_rst     <= '1;
            r_timeout <= 1'b0;
            r_fail    <= '0;
            r_hb      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_k       <= w_k_nxt;
            r_retry   <= w_retry_nxt;
            r_rst     <= w_rst_nxt;
            r_timeout <= w_timeout_nxt;
            r_fail    <= w_fail_nxt;
            r_hb      <= r_hb + 1'b1;
        end
    end

    assign rst_o        = r_rst;
    assign all_done_o   = (r_state == S_RUN);
    assign fault_o      = (r_state == S_FAULT);
    assign timeout_o    = r_timeout;
    assign fail_stage_o = r_fail;
    assign state_o      = r_state;
    // Blink 8x faster in FAULT so the LED alone distinguishes a hang from a fault.
    assign heartbeat_o  = (r_state == S_FAULT) ? r_hb[HB_BIT-3] : r_hb[HB_BIT];

endmodule
